// File: rtl/cdb_wb_arbiter_if.sv
// Writeback bus between the execution units and the CDB arbiter.
// The arbiter takes the master modport; execution units and ROB/RRF observers take slave.
interface cdb_wb_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 6
);
    localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ-1:0]        req_rob_we;
    logic [NUM_REQ-1:0]        req_rrf_we;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      cdb_valid;
    logic [DATA_W-1:0]         cdb_data;
    logic [TAG_W-1:0]          cdb_tag;
    logic                      cdb_rob_we;
    logic                      cdb_rrf_we;
    logic [SRC_W-1:0]          cdb_src;

    modport master (
        input  req_valid, req_data, req_tag, req_rob_we, req_rrf_we,
        output req_ready,
        output cdb_valid, cdb_data, cdb_tag, cdb_rob_we, cdb_rrf_we, cdb_src
    );

    modport slave (
        output req_valid, req_data, req_tag, req_rob_we, req_rrf_we,
        input  req_ready,
        input  cdb_valid, cdb_data, cdb_tag, cdb_rob_we, cdb_rrf_we, cdb_src
    );
endinterface

// File: rtl/cdb_wb_arbiter.sv
// Round-robin writeback arbiter: one-entry holding buffer per execution unit, one registered
// CDB broadcast per cycle into the ROB and rename register file.
module cdb_wb_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 6
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    cdb_wb_arbiter_if.master bus
);
    localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [SRC_W:0]   LP_NREQ = (SRC_W + 1)'(NUM_REQ);
    localparam logic [SRC_W-1:0] LP_LAST = SRC_W'(NUM_REQ - 1);

    // Holding buffers
    logic [NUM_REQ-1:0] r_full;
    logic [DATA_W-1:0]  r_buf_data [NUM_REQ];
    logic [TAG_W-1:0]   r_buf_tag  [NUM_REQ];
    logic [NUM_REQ-1:0] r_buf_rob_we;
    logic [NUM_REQ-1:0] r_buf_rrf_we;

    // Round-robin pointer and broadcast registers
    logic [SRC_W-1:0]   r_ptr;
    logic               r_cdb_valid;
    logic [DATA_W-1:0]  r_cdb_data;
    logic [TAG_W-1:0]   r_cdb_tag;
    logic               r_cdb_rob_we;
    logic               r_cdb_rrf_we;
    logic [SRC_W-1:0]   r_cdb_src;

    logic               w_found;
    logic [SRC_W-1:0]   w_gnt_idx;
    logic [SRC_W:0]     w_scan;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_ready;
    logic [NUM_REQ-1:0] w_capture;
    logic [SRC_W-1:0]   w_ptr_nxt;

    // Circular search from r_ptr; only registered state feeds the grant.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            w_scan = {1'b0, r_ptr} + (SRC_W + 1)'(k);
            if (w_scan >= LP_NREQ) begin
                w_scan = w_scan - LP_NREQ;
            end
            if (!w_found && r_full[w_scan[SRC_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_found) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    assign w_ptr_nxt = (w_gnt_idx == LP_LAST) ? '0 : w_gnt_idx + 1'b1;

    // A granted buffer drains this edge, so it may be refilled at the same time.
    assign w_ready   = (~r_full | w_grant) & {NUM_REQ{~flush_i}};
    assign w_capture = bus.req_valid & w_ready;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_full       <= '0;
            r_buf_rob_we <= '0;
            r_buf_rrf_we <= '0;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                r_buf_data[i] <= '0;
                r_buf_tag[i]  <= '0;
            end
        end else if (flush_i) begin
            r_full <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (w_capture[i]) begin
                    r_full[i]       <= 1'b1;
                    r_buf_data[i]   <= bus.req_data[i*DATA_W +: DATA_W];
                    r_buf_tag[i]    <= bus.req_tag[i*TAG_W +: TAG_W];
                    r_buf_rob_we[i] <= bus.req_rob_we[i];
                    r_buf_rrf_we[i] <= bus.req_rrf_we[i];
                end else if (w_grant[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    // Data/tag/src hold on idle or flush cycles; only valid and the write enables drop.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_ptr        <= '0;
            r_cdb_valid  <= 1'b0;
            r_cdb_data   <= '0;
            r_cdb_tag    <= '0;
            r_cdb_rob_we <= 1'b0;
            r_cdb_rrf_we <= 1'b0;
            r_cdb_src    <= '0;
        end else if (flush_i) begin
            r_cdb_valid  <= 1'b0;
            r_cdb_rob_we <= 1'b0;
            r_cdb_rrf_we <= 1'b0;
        end else if (w_found) begin
            r_cdb_valid  <= 1'b1;
            r_cdb_data   <= r_buf_data[w_gnt_idx];
            r_cdb_tag    <= r_buf_tag[w_gnt_idx];
            r_cdb_rob_we <= r_buf_rob_we[w_gnt_idx];
            r_cdb_rrf_we <= r_buf_rrf_we[w_gnt_idx];
            r_cdb_src    <= w_gnt_idx;
            r_ptr        <= w_ptr_nxt;
        end else begin
            r_cdb_valid  <= 1'b0;
            r_cdb_rob_we <= 1'b0;
            r_cdb_rrf_we <= 1'b0;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.cdb_valid  = r_cdb_valid;
    assign bus.cdb_data   = r_cdb_data;
    assign bus.cdb_tag    = r_cdb_tag;
    assign bus.cdb_rob_we = r_cdb_rob_we;
    assign bus.cdb_rrf_we = r_cdb_rrf_we;
    assign bus.cdb_src    = r_cdb_src;
endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Directed and randomized bench for cdb_wb_arbiter against a buffer/pointer reference model.
module tb_cdb_wb_arbiter;
    localparam int N = 4;
    localparam int D = 32;
    localparam int T = 6;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    always #5 clk = ~clk;

    cdb_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(D), .TAG_W(T)) bus ();

    cdb_wb_arbiter #(.NUM_REQ(N), .DATA_W(D), .TAG_W(T)) dut (
        .clk_i   (clk),
        .reset_i (reset_n),
        .flush_i (flush),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus values per requester
    logic [D-1:0] in_data [N];
    logic [T-1:0] in_tag  [N];
    logic [N-1:0] in_rob;
    logic [N-1:0] in_rrf;

    // Reference model state
    bit           m_full [N];
    logic [D-1:0] m_data [N];
    logic [T-1:0] m_tag  [N];
    bit           m_rob  [N];
    bit           m_rrf  [N];
    int           m_ptr;
    logic         m_cv, m_crob, m_crrf;
    logic [D-1:0] m_cd;
    logic [T-1:0] m_ct;
    int           m_src;
    logic [N-1:0] m_ready;

    int           grants [N];
    logic [N-1:0] hold;
    logic [N-1:0] v;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_full[i] = 0; m_data[i] = '0; m_tag[i] = '0; m_rob[i] = 0; m_rrf[i] = 0;
        end
        m_ptr = 0; m_cv = 0; m_crob = 0; m_crrf = 0; m_cd = '0; m_ct = '0; m_src = 0;
    endtask

    // Entered at a negedge; drives inputs, checks the cycle, advances one clock edge.
    task automatic step(input logic [N-1:0] valid, input logic fl);
        int g;
        int idx;
        bus.req_valid  = valid;
        bus.req_rob_we = in_rob;
        bus.req_rrf_we = in_rrf;
        for (int i = 0; i < N; i++) begin
            bus.req_data[i*D +: D] = in_data[i];
            bus.req_tag[i*T +: T]  = in_tag[i];
        end
        flush = fl;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && m_full[idx]) g = idx;
        end
        for (int i = 0; i < N; i++) m_ready[i] = (!m_full[i] || i == g) && !fl;
        chk("req_ready", bus.req_ready, m_ready);
        chk("cdb_valid", bus.cdb_valid, m_cv);
        chk("cdb_data", bus.cdb_data, m_cd);
        chk("cdb_tag", bus.cdb_tag, m_ct);
        chk("cdb_rob_we", bus.cdb_rob_we, m_crob);
        chk("cdb_rrf_we", bus.cdb_rrf_we, m_crrf);
        chk("cdb_src", bus.cdb_src, m_src);
        @(posedge clk);
        if (fl) begin
            for (int i = 0; i < N; i++) m_full[i] = 0;
            m_cv = 0; m_crob = 0; m_crrf = 0;
        end else begin
            if (g >= 0) begin
                m_cv = 1; m_cd = m_data[g]; m_ct = m_tag[g];
                m_crob = m_rob[g]; m_crrf = m_rrf[g]; m_src = g;
                m_ptr = (g + 1) % N; m_full[g] = 0;
            end else begin
                m_cv = 0; m_crob = 0; m_crrf = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (valid[i] && m_ready[i]) begin
                    m_full[i] = 1; m_data[i] = in_data[i]; m_tag[i] = in_tag[i];
                    m_rob[i] = in_rob[i]; m_rrf[i] = in_rrf[i];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.req_valid = '0;
        flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n = 1'b0;
        flush = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.req_tag = '0;
        bus.req_rob_we = '0;
        bus.req_rrf_we = '0;
        in_rob = '1;
        in_rrf = '1;
        for (int i = 0; i < N; i++) begin in_data[i] = '0; in_tag[i] = '0; end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("idle_ready", bus.req_ready, 4'b1111);
        chk("idle_valid", bus.cdb_valid, 1'b0);
        @(negedge clk);

        // Single requester back-to-back
        in_data[2] = 32'h11; in_tag[2] = 6'd5; step(4'b0100, 1'b0);
        chk("single_first_valid", bus.cdb_valid, 1'b0);
        in_data[2] = 32'h22; in_tag[2] = 6'd6; step(4'b0100, 1'b0);
        chk("single_valid0", bus.cdb_valid, 1'b1);
        chk("single_data0", bus.cdb_data, 32'h11);
        chk("single_tag0", bus.cdb_tag, 6'd5);
        chk("single_src0", bus.cdb_src, 2'd2);
        in_data[2] = 32'h33; in_tag[2] = 6'd7; step(4'b0100, 1'b0);
        chk("single_data1", bus.cdb_data, 32'h22);
        chk("single_tag1", bus.cdb_tag, 6'd6);
        step(4'b0000, 1'b0);
        chk("single_valid2", bus.cdb_valid, 1'b1);
        chk("single_data2", bus.cdb_data, 32'h33);
        chk("single_tag2", bus.cdb_tag, 6'd7);
        step(4'b0000, 1'b0);
        chk("single_idle", bus.cdb_valid, 1'b0);

        // Full contention from pointer 0
        do_reset();
        for (int i = 0; i < N; i++) grants[i] = 0;
        for (int s = 0; s < 9; s++) begin
            for (int i = 0; i < N; i++) begin
                in_data[i] = 32'h1000 + 32'(s * 16 + i);
                in_tag[i] = 6'(s * 4 + i);
            end
            step(4'b1111, 1'b0);
            if (s >= 1) begin
                chk("contention_src", bus.cdb_src, 64'((s - 1) % 4));
                if (bus.cdb_valid) grants[bus.cdb_src]++;
            end
        end
        for (int i = 0; i < N; i++) chk("contention_grants", grants[i], 2);

        // Asynchronous reset while a broadcast is on the bus
        chk("pre_reset_valid", bus.cdb_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.cdb_valid, 1'b0);
        chk("async_rst_data", bus.cdb_data, 32'h0);
        chk("async_rst_tag", bus.cdb_tag, 6'h0);
        chk("async_rst_rob", bus.cdb_rob_we, 1'b0);
        chk("async_rst_rrf", bus.cdb_rrf_we, 1'b0);
        chk("async_rst_src", bus.cdb_src, 2'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        bus.req_valid = '0;

        // Pointer skip: buffers 1 and 3 full with pointer 2
        in_data[1] = 32'hA1; in_data[3] = 32'hA3;
        step(4'b0010, 1'b0);
        in_data[1] = 32'hB1;
        step(4'b1010, 1'b0);
        chk("skip_setup_src", bus.cdb_src, 2'd1);
        chk("skip_setup_ptr", dut.r_ptr, 2'd2);
        step(4'b0000, 1'b0);
        chk("skip_src_a", bus.cdb_src, 2'd3);
        chk("skip_ptr_a", dut.r_ptr, 2'd0);
        step(4'b0000, 1'b0);
        chk("skip_src_b", bus.cdb_src, 2'd1);
        chk("skip_data_b", bus.cdb_data, 32'hB1);
        chk("skip_ptr_b", dut.r_ptr, 2'd2);

        // Write-enable passthrough
        in_data[0] = 32'hDEADBEEF; in_rob[0] = 1'b1; in_rrf[0] = 1'b0;
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        chk("we_valid", bus.cdb_valid, 1'b1);
        chk("we_rob", bus.cdb_rob_we, 1'b1);
        chk("we_rrf", bus.cdb_rrf_we, 1'b0);
        chk("we_data", bus.cdb_data, 32'hDEADBEEF);
        in_rrf[0] = 1'b1;

        // Flush with buffers 0, 1, 3 full
        in_data[0] = 32'hF0; in_data[1] = 32'hF1; in_data[3] = 32'hF3;
        step(4'b1011, 1'b0);
        step(4'b0000, 1'b1);
        chk("flush_valid_after", bus.cdb_valid, 1'b0);
        in_data[1] = 32'h55;
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        chk("post_flush_valid", bus.cdb_valid, 1'b1);
        chk("post_flush_data", bus.cdb_data, 32'h55);
        chk("post_flush_src", bus.cdb_src, 2'd1);
        repeat (3) step(4'b0000, 1'b0);

        // Randomized traffic; a stalled requester keeps its payload stable
        hold = '0;
        v = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!hold[i]) begin
                    v[i] = ($urandom_range(0, 3) != 0);
                    in_data[i] = $urandom;
                    in_tag[i] = T'($urandom);
                    in_rob[i] = 1'($urandom);
                    in_rrf[i] = 1'($urandom);
                end
            end
            step(v, $urandom_range(0, 15) == 0);
            hold = v & ~m_ready;
        end
        step(4'b0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdb_wb_arbiter.md
Name: cdb_wb_arbiter

Overview:
- Round-robin writeback arbiter that shares the single result/ROB/rename-register write bus between NUM_REQ execution units.
- Requesters are ALU pipes, branch, mul and LSU.
- Each requester hands its result to a one-entry holding buffer using a valid/ready handshake.
- The arbiter grants one full buffer per cycle and drives a registered broadcast bus into the reorder buffer and rename register file.

Parameters:
NUM_REQ, 4, number of requesting execution units (2..8)
DATA_W, 32, result width (matches DATA_LEN)
TAG_W, 6, rename register tag width (matches RRF_SEL)

Ports:
clk_i  input  1  clock, all state on rising edge
reset_i  input  1  asynchronous, active-low reset; clears all state
flush_i  input  1  synchronous pipeline kill (mispredict); drops all pending results
req_valid_i  input  NUM_REQ  per-requester result valid
req_data_i  input  NUM_REQ*DATA_W  per-requester result; slice i = [i*DATA_W +: DATA_W]
req_tag_i  input  NUM_REQ*TAG_W  per-requester rrf tag
req_rob_we_i  input  NUM_REQ  per-requester reorder-buffer write enable
req_rrf_we_i  input  NUM_REQ  per-requester rename-register write enable
req_ready_o  output  NUM_REQ  holding buffer i can accept this cycle
cdb_valid_o  output  1  broadcast valid (registered)
cdb_data_o  output  DATA_W  broadcast result (registered)
cdb_tag_o  output  TAG_W  broadcast rrf tag (registered)
cdb_rob_we_o  output  1  registered; equals winner's rob_we ANDed with valid
cdb_rrf_we_o  output  1  registered; equals winner's rrf_we ANDed with valid
cdb_src_o  output  clog2(NUM_REQ)  index of the requester that produced the current broadcast (debug/perf)

Behaviour:
- Reset (reset_i low, asynchronous):
  - all buffers empty; priority pointer = 0;
  - cdb_valid_o, cdb_rob_we_o, cdb_rrf_we_o = 0; cdb_data_o, cdb_tag_o, cdb_src_o = 0;
  - req_ready_o = all ones once reset is released.
- Holding buffer i: full[i] plus data, tag, rob_we and rrf_we.
  - Capture occurs on the clock edge when req_valid_i[i] && req_ready_o[i] && !flush_i.
- Arbitration is combinational from registered state only (full vector and pointer). There is no path from req_valid_i to the grant.
  - grant = first full buffer searched circularly starting at pointer.
  - At most one grant per cycle; no grant if nothing is full.
- req_ready_o[i] = (!full[i] || grant[i]) && !flush_i.
  - A granted buffer is refilled in the same edge, giving 1 result/cycle per requester with no bubble.
- On an edge with a grant g:
  - broadcast registers load buffer g;
  - cdb_valid_o = 1 and cdb_src_o = g;
  - full[g] clears, unless it is refilled in the same edge;
  - pointer = (g+1) mod NUM_REQ.
- On an edge with no grant: cdb_valid_o = 0, the write enables = 0, data/tag hold their values, and the pointer holds.
- Latency: data captured at edge t is broadcast no earlier than edge t+1, so cdb_valid_o is high during cycle t+1.
  - With no contention, latency is exactly 1 cycle from the handshake to cdb_valid_o.
- Fairness: a full buffer is granted within NUM_REQ cycles. No requester starves under continuous contention.
- flush_i (synchronous, has priority over everything except reset):
  - at the edge, all full bits clear, cdb_valid_o and the write enables go to 0, and nothing is captured;
  - req_ready_o = 0 during the flush cycle;
  - the pointer is unchanged.
- A requester holding req_valid_i while not ready must keep its data stable. The arbiter does not check this.
- Pointer wrap: when NUM_REQ is not a power of 2, the increment is modulo NUM_REQ, never an out-of-range index.

Test Plan:
- Reset then idle:
  - after reset_i rises, req_ready_o = 4'b1111 and cdb_valid_o = 0;
  - assert reset_i low mid-broadcast -> all outputs 0 immediately, with no clock edge needed.
- Single requester, back-to-back: req 2 valid for 3 cycles with data 0x11, 0x22, 0x33 and tag 5, 6, 7 -> cdb_valid_o high for 3 consecutive cycles starting 1 cycle after the first handshake, with data and tags in order, cdb_src_o = 2, and ready held at 1.
- Full contention: all 4 requesters valid every cycle with pointer = 0 -> cdb_src_o sequence is 0, 1, 2, 3, 0, 1, ...; every requester gets exactly 1 grant per 4 cycles.
- Pointer skip: only buffers 1 and 3 full with pointer = 2 -> grants go to 3 then 1, and the pointer becomes 0 then 2.
- Write-enable passthrough: requester 0 sends rob_we = 1, rrf_we = 0 (store-like) and data 0xDEADBEEF -> cdb_rob_we_o = 1, cdb_rrf_we_o = 0, cdb_data_o = 0xDEADBEEF.
- Flush: buffers 0, 1 and 3 full, then flush_i for 1 cycle -> req_ready_o = 0 during the flush cycle; cdb_valid_o = 0 in the next cycle and no stale results are ever broadcast; a new req 1 with 0x55 is broadcast 1 cycle after its handshake.
